sched_shuffle_reg: RTL
======================

Name: sched_shuffle_reg

Overview:
- Parametrised successor to the phase-scheduled two-register shuffler.
- A phase counter with a programmable period selects, per phase, one routing operation over a DEPTH-deep register bank and a registered output.
- The per-phase operation table is runtime-writable; reset loads the legacy 9-phase pattern.
- Sits in the datapath as a scheduled reorder/delay stage between a byte source and a downstream consumer.

Parameters:
- WIDTH, 8, data width of in, the bank registers and out.
- DEPTH, 2, number of bank registers R[0..DEPTH-1]; legal range 1..8.
- PERIOD, 9, phase count; legal range 2..16.
- PW, 4, phase counter width; must satisfy 2**PW >= PERIOD.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance enable; 0 freezes the phase counter and the bank.
- in  input  WIDTH  input data.
- cfg_we  input  1  op-table write strobe.
- cfg_addr  input  PW  phase index to write.
- cfg_op  input  2  op code to write.
- out  output  WIDTH  registered output data.
- out_valid  output  1  out was updated by a non-HOLD op in the previous cycle.
- q  output  PW  current phase.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset values:
  - q = PERIOD-1.
  - R[*] = 0.
  - out = 0.
  - out_valid = 0.
  - Op table = default pattern: phases 0,1,2,5,6 SHIFT; phase 3 BYPASS_SWAP; phases 4,7,8 TAP; any phase >= 9 SHIFT.
  - rst overrides en, cfg_we and every other input.
- Phase counter (en=1): q <= (q == PERIOD-1) ? 0 : q+1.
- The op executed in a cycle is op_table[q], using the current q.
- Op codes:
  - 0 SHIFT: out <= R[DEPTH-1]; R[i] <= R[i-1] for i >= 1; R[0] <= in.
  - 1 BYPASS_SWAP: out <= in; R[0] and R[DEPTH-1] exchange contents; the middle registers hold. With DEPTH=1 the swap is a no-op.
  - 2 TAP: out <= R[0]; R[0] <= in; R[1..DEPTH-1] hold.
  - 3 HOLD: bank and out unchanged.
- Latency:
  - SHIFT path: DEPTH+1 cycles from in to out.
  - BYPASS: 1 cycle.
  - TAP: 2 cycles.
- out_valid:
  - en=1: out_valid <= (op != HOLD).
  - en=0: out_valid <= 0.
- Stall (en=0): q, the bank and out hold; the op table still accepts writes.
- Config writes:
  - cfg_we=1 writes op_table[cfg_addr] <= cfg_op, regardless of en.
  - cfg_addr >= PERIOD: the write is ignored.
  - A write to the current q in the same cycle does not affect this cycle's op; the new op takes effect on the next visit to that phase.
- Wrap-around: q never exceeds PERIOD-1.
- Reset mid-period: the next cycle restarts at phase PERIOD-1 with a cleared bank, and the op table returns to the default pattern.

Optional Feature:
- Macro: PHASE_SYNC_EN.
- Defined:
  - Adds input port sync (1 bit).
  - When en=1 and sync=1, the current op executes normally, then q <= 0 instead of the normal increment.
  - When en=0, sync is ignored.
  - rst has priority over sync.
- Undefined: no sync port; the phase counter free-runs per the rules above.

Test Plan:
- Default pattern, DEPTH=2: rst, then in = 0x11,0x22,0x33,0x44,0x55 on consecutive cycles with en=1 -> q sequence 8,0,1,2,3; out after each edge = 0x00,0x00,0x11,0x22,0x55; after the 5th edge R0=0x33, R1=0x44.
- Wrap: run 20 cycles with en=1 -> q runs 8,0..8,0..8,0, never reaching 9; out_valid stays 1 throughout.
- Stall: at q=2 hold en=0 for 3 cycles with in toggling -> q, R and out frozen, out_valid=0; on release the sequence resumes at phase 2.
- Config: write phase 3 = HOLD during phase 1 -> at phase 3 out and the bank are unchanged and out_valid=0. Also write cfg_addr=3 while q=3 -> the old op is used this cycle. A write to cfg_addr=12 has no effect.
- Reset mid-operation: assert rst at q=5 with a non-zero bank and a reprogrammed table -> next cycle q=8, out=0, R=0, default table restored.
- PHASE_SYNC_EN build: pulse sync at q=5 -> the phase-5 SHIFT executes and q=0 next cycle. Sync with en=0 -> ignored.

Source files
------------

// File: rtl/sched_shuffle_reg_if.sv
// Bus bundle for sched_shuffle_reg: stream data, op-table config port and phase/status outputs.
// The sync field exists only when PHASE_SYNC_EN is defined.
interface sched_shuffle_reg_if #(
    parameter int WIDTH = 8,
    parameter int PW    = 4
);
    logic             en;
    logic [WIDTH-1:0] in;
    logic             cfg_we;
    logic [PW-1:0]    cfg_addr;
    logic [1:0]       cfg_op;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [PW-1:0]    q;
`ifdef PHASE_SYNC_EN
    logic             sync;
`endif

    modport master (
`ifdef PHASE_SYNC_EN
        output sync,
`endif
        output en, in, cfg_we, cfg_addr, cfg_op,
        input  out, out_valid, q
    );

    modport slave (
`ifdef PHASE_SYNC_EN
        input  sync,
`endif
        input  en, in, cfg_we, cfg_addr, cfg_op,
        output out, out_valid, q
    );
endinterface

// File: rtl/sched_shuffle_reg.sv
// Phase-scheduled reorder/delay stage: a programmable-period phase counter picks one routing op per
// phase over a DEPTH-deep register bank. Optional macro PHASE_SYNC_EN adds a phase-restart input.
module sched_shuffle_reg #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2,
    parameter int PERIOD = 9,
    parameter int PW     = 4
) (
    input logic               clk,
    input logic               rst,
    sched_shuffle_reg_if.slave bus
);

    typedef enum logic [1:0] {
        OP_SHIFT       = 2'd0,
        OP_BYPASS_SWAP = 2'd1,
        OP_TAP         = 2'd2,
        OP_HOLD        = 2'd3
    } op_e;

    // The table spans every encodable phase so q and cfg_addr index it without narrowing.
    localparam int              TABLE_SIZE = 2 ** PW;
    localparam logic [PW-1:0]   LAST_PHASE = PW'(PERIOD - 1);
    localparam logic [PW:0]     PERIOD_EXT = (PW + 1)'(PERIOD);

    function automatic op_e default_op(input int phase);
        op_e op;
        case (phase)
            3:       op = OP_BYPASS_SWAP;
            4, 7, 8: op = OP_TAP;
            default: op = OP_SHIFT;
        endcase
        return op;
    endfunction

    logic [PW-1:0]    phase;
    logic [PW-1:0]    phase_nxt;
    op_e              op_table [TABLE_SIZE];
    op_e              cur_op;
    logic [WIDTH-1:0] bank     [DEPTH];
    logic [WIDTH-1:0] bank_nxt [DEPTH];
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_nxt;
    logic             valid_reg;
    logic             valid_nxt;
    logic             cfg_hit;
    logic             restart;

`ifdef PHASE_SYNC_EN
    assign restart = bus.sync;
`else
    assign restart = 1'b0;
`endif

    assign cfg_hit = bus.cfg_we && ({1'b0, bus.cfg_addr} < PERIOD_EXT);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= LAST_PHASE;
            out_reg   <= '0;
            valid_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
            for (int p = 0; p < TABLE_SIZE; p++) begin
                op_table[p] <= default_op(p);
            end
        end else begin
            phase     <= phase_nxt;
            out_reg   <= out_nxt;
            valid_reg <= valid_nxt;
            bank      <= bank_nxt;
            if (cfg_hit) begin
                op_table[bus.cfg_addr] <= op_e'(bus.cfg_op);
            end
        end
    end

    always_comb begin
        phase_nxt = phase;
        if (bus.en) begin
            if (restart || phase == LAST_PHASE) begin
                phase_nxt = '0;
            end else begin
                phase_nxt = phase + PW'(1);
            end
        end
    end

    // A same-cycle table write lands after this read, so the current phase keeps its old op.
    always_comb begin
        cur_op    = op_table[phase];
        valid_nxt = bus.en && (cur_op != OP_HOLD);
        out_nxt   = out_reg;
        bank_nxt  = bank;
        if (bus.en) begin
            case (cur_op)
                OP_SHIFT: begin
                    out_nxt = bank[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) begin
                        bank_nxt[i] = bank[i-1];
                    end
                    bank_nxt[0] = bus.in;
                end
                OP_BYPASS_SWAP: begin
                    out_nxt           = bus.in;
                    bank_nxt[0]       = bank[DEPTH-1];
                    bank_nxt[DEPTH-1] = bank[0];
                end
                OP_TAP: begin
                    out_nxt     = bank[0];
                    bank_nxt[0] = bus.in;
                end
                default: begin
                    out_nxt = out_reg;
                end
            endcase
        end
    end

    assign bus.out       = out_reg;
    assign bus.out_valid = valid_reg;
    assign bus.q         = phase;

endmodule
